// File: rtl/wb_neopx_stream.sv
// Wishbone pixel buffer that streams its LED words over an AXI-Stream master,
// with single-shot START, one-deep pending restart and auto-repeat with a gap.
module wb_neopx_stream #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4,
  parameter int NUM_LEDS     = 8,
  parameter int GAP_CYCLES   = 4000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_sel_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [DATA_WIDTH-1:0]   m_axis_data,
  output logic                    m_axis_valid,
  output logic                    m_axis_last,
  input  logic                    s_axis_ready
);

  localparam int         IW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int         DEPTH    = 1 << IW;
  localparam logic [6:0] NL       = 7'(NUM_LEDS);
  localparam logic [31:0] GAP_INIT = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;

  state_t                state_q;
  logic                  ack_q, auto_q, pend_q, valid_q, last_q;
  logic [DATA_WIDTH-1:0] dat_q, data_q;
  logic [6:0]            len_q, flen_q, idx_q, len_eff;
  logic [31:0]           gap_q;
  logic [DATA_WIDTH-1:0] buf_q [DEPTH];

  logic                  acc, wr, hit_led, start_w, go;
  logic [6:0]            wadr;
  logic [IW-1:0]         led_idx, fetch_idx;
  logic [DATA_WIDTH-1:0] bmask, rdata, fetch_word;
  logic                  unused_ok;

  assign acc       = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr        = acc & wb_we_i;
  assign wadr      = wb_adr_i[8:2];
  assign hit_led   = wadr[6] && ({1'b0, wadr[5:0]} < NL);
  assign led_idx   = wadr[IW-1:0];
  assign start_w   = wr && (wadr == 7'd0) && wb_sel_i[0] && wb_dat_i[0];
  assign len_eff   = (len_q == 7'd0 || len_q > NL) ? NL : len_q;
  assign unused_ok = ^{wb_adr_i[ADDR_WIDTH-1:9], wb_adr_i[1:0]};

  // A frame starts from IDLE on START/pending, or at gap end when more frames are owed.
  assign go = (state_q == S_IDLE && (start_w || pend_q)) ||
              (state_q == S_GAP && gap_q == 32'd0 && (auto_q || pend_q));

  assign fetch_idx = go ? '0 : IW'(idx_q + 7'd1);

  // Byte-lane mask from the Wishbone selects
  always_comb begin
    bmask = '0;
    for (int b = 0; b < SELECT_WIDTH; b++) bmask[8*b +: 8] = {8{wb_sel_i[b]}};
  end

  // Word about to be presented; a same-cycle write to that LED is forwarded
  always_comb begin
    fetch_word = buf_q[fetch_idx];
    if (wr && hit_led && led_idx == fetch_idx)
      fetch_word = (fetch_word & ~bmask) | (wb_dat_i & bmask);
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (wadr)
      7'd0:    rdata = DATA_WIDTH'({auto_q, 1'b0});
      7'd1:    rdata = DATA_WIDTH'({1'b0, idx_q, 4'b0, state_q, pend_q, state_q != S_IDLE});
      7'd2:    rdata = DATA_WIDTH'(len_q);
      default: if (hit_led) rdata = buf_q[led_idx];
    endcase
  end

  // Wishbone handshake, read data and control registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      auto_q <= 1'b0;
      len_q  <= NL;
    end else begin
      ack_q <= acc;
      if (acc) dat_q <= rdata;
      if (wr && wadr == 7'd0 && wb_sel_i[0]) auto_q <= wb_dat_i[1];
      if (wr && wadr == 7'd2 && wb_sel_i[0]) len_q  <= wb_dat_i[6:0];
    end
  end

  // Pixel buffer with byte-enable writes
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (wr && hit_led) begin
      buf_q[led_idx] <= (buf_q[led_idx] & ~bmask) | (wb_dat_i & bmask);
    end
  end

  // Stream FSM: presents one word per clock, holds on stall, gaps between repeats
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      flen_q  <= NL;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      if (go) begin
        state_q <= S_SEND;
        pend_q  <= 1'b0;
        idx_q   <= '0;
        flen_q  <= len_eff;
        valid_q <= 1'b1;
        data_q  <= fetch_word;
        last_q  <= (len_eff == 7'd1);
      end else begin
        case (state_q)
          S_SEND: if (valid_q && s_axis_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (auto_q || pend_q || start_w) begin
                state_q <= S_GAP;
                gap_q   <= GAP_INIT;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              idx_q  <= idx_q + 7'd1;
              data_q <= fetch_word;
              last_q <= (idx_q + 7'd2 == flen_q);
            end
          end
          S_GAP: if (gap_q == 32'd0) state_q <= S_IDLE;
                 else gap_q <= gap_q - 32'd1;
          default: state_q <= S_IDLE;
        endcase
      end
      // START while busy owes exactly one more frame
      if (start_w && state_q != S_IDLE) pend_q <= 1'b1;
    end
  end

  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;
  assign wb_err_o     = 1'b0;
  assign wb_rty_o     = 1'b0;
  assign m_axis_data  = data_q;
  assign m_axis_valid = valid_q;
  assign m_axis_last  = last_q;

endmodule

// File: tb/tb_wb_neopx_stream.sv
// Bench for wb_neopx_stream: register vectors, frame sequences, random frames vs model.
module tb_wb_neopx_stream;
  localparam int NL  = 8;
  localparam int GAP = 16;

  logic        clk = 0, rst_n = 0;
  logic [31:0] adr = 0, dat_i = 0, dat_o;
  logic        we = 0, stb = 0, cyc = 0, ack, err, rty;
  logic [3:0]  sel = 0;
  logic [31:0] ax_data;
  logic        ax_valid, ax_last, ax_ready = 1;

  int total = 0, bad = 0, cyc_n = 0;
  int rmode = 0;  // 0 high, 1 toggle, 2 random, 3 low, 4 one-cycle high then low

  typedef struct { logic [31:0] data; logic last; int stamp; } beat_t;
  beat_t beats[$];
  logic [31:0] mbuf [NL];

  wb_neopx_stream #(.NUM_LEDS(NL), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_we_i(we),
    .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty),
    .m_axis_data(ax_data), .m_axis_valid(ax_valid), .m_axis_last(ax_last),
    .s_axis_ready(ax_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return (o & ~m) | (d & m);
  endfunction

  function automatic int eff_len(input int raw);
    return (raw == 0 || raw > NL) ? NL : raw;
  endfunction

  // ready pattern generator
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: ax_ready = 1'b1;
      1: ax_ready = ~ax_ready;
      2: ax_ready = 1'($urandom % 2);
      4: begin ax_ready = 1'b1; rmode = 3; end
      default: ax_ready = 1'b0;
    endcase
  end

  // beat collector and stall-stability checker
  logic        pstall = 0, plast = 0;
  logic [31:0] pdata = 0;
  always @(negedge clk) begin
    beat_t bt;
    cyc_n++;
    if (!rst_n) pstall = 0;
    else begin
      if (pstall) begin
        chk("hold_valid", 32'(ax_valid), 1);
        chk("hold_data", ax_data, pdata);
        chk("hold_last", 32'(ax_last), 32'(plast));
      end
      if (ax_valid && ax_ready) begin
        bt.data = ax_data; bt.last = ax_last; bt.stamp = cyc_n;
        beats.push_back(bt);
      end
      pstall = ax_valid && !ax_ready;
      pdata  = ax_data;
      plast  = ax_last;
    end
  end

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd);
    @(posedge clk); #1;
    chk("ack_single", 32'(ack), 0);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    @(posedge clk); #1;
    chk("ack", 32'(ack), 1);
    rd = dat_o;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wbw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] x;
    wb(1'b1, a, d, s, x);
  endtask

  task automatic rdc(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] x;
    wb(1'b0, a, 32'h0, 4'h0, x);
    chk(name, x, exp);
  endtask

  task automatic led_wr(input int i, input logic [31:0] d, input logic [3:0] s);
    wbw(32'(32'h100 + 4 * i), d, s);
    if (i < NL) mbuf[i] = merge(mbuf[i], d, s);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (beats.size() < n && c < budget) begin
      @(negedge clk); c++;
    end
    chk("beat_count", beats.size(), n);
  endtask

  task automatic check_frame(input string name, input int off, input int raw);
    int e = eff_len(raw);
    for (int k = 0; k < e; k++) begin
      if (off + k < beats.size()) begin
        chk({name, "_data"}, beats[off+k].data, mbuf[k]);
        chk({name, "_last"}, 32'(beats[off+k].last), 32'(k == e - 1));
      end
    end
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int n = 0;
    do begin
      wb(1'b0, 32'h4, 0, 0, st); n++;
    end while (st[0] && n < 200);
    chk("idle_reached", 32'(st[0]), 0);
  endtask

  typedef struct { logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s; logic [31:0] exp; } vec_t;
  vec_t tv [18];

  initial begin
    logic [31:0] st, old0, tmp;
    int n, raw;
    tv[0]  = '{1'b1, 32'h104, 32'hFFFFFFFF, 4'b0010, 32'h0};
    tv[1]  = '{1'b0, 32'h104, 32'h0, 4'h0, 32'h0000FF00};
    tv[2]  = '{1'b1, 32'h100, 32'hA5A5A5A5, 4'hF, 32'h0};
    tv[3]  = '{1'b1, 32'h100, 32'h00000012, 4'b0001, 32'h0};
    tv[4]  = '{1'b0, 32'h100, 32'h0, 4'h0, 32'hA5A5A512};
    tv[5]  = '{1'b1, 32'h11C, 32'h12345678, 4'b1100, 32'h0};
    tv[6]  = '{1'b0, 32'h11C, 32'h0, 4'h0, 32'h12340000};
    tv[7]  = '{1'b1, 32'h120, 32'hDEADBEEF, 4'hF, 32'h0};
    tv[8]  = '{1'b0, 32'h120, 32'h0, 4'h0, 32'h0};
    tv[9]  = '{1'b0, 32'h200, 32'h0, 4'h0, 32'h0};
    tv[10] = '{1'b1, 32'h008, 32'h0000007F, 4'b0001, 32'h0};
    tv[11] = '{1'b0, 32'h008, 32'h0, 4'h0, 32'h7F};
    tv[12] = '{1'b1, 32'h008, 32'h00000003, 4'b0010, 32'h0};
    tv[13] = '{1'b0, 32'h008, 32'h0, 4'h0, 32'h7F};
    tv[14] = '{1'b1, 32'h008, 32'h00000005, 4'hF, 32'h0};
    tv[15] = '{1'b0, 32'h008, 32'h0, 4'h0, 32'h5};
    tv[16] = '{1'b0, 32'h00C, 32'h0, 4'h0, 32'h0};
    tv[17] = '{1'b0, 32'h004, 32'h0, 4'h0, 32'h0};
    for (int i = 0; i < NL; i++) mbuf[i] = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ax_valid), 0);
    chk("rst_last", 32'(ax_last), 0);
    chk("rst_data", ax_data, 0);
    chk("rst_ack", 32'(ack), 0);
    chk("err_tied", 32'(err), 0);
    chk("rty_tied", 32'(rty), 0);
    rst_n = 1;
    rdc("rst_status", 32'h4, 0);
    rdc("rst_len", 32'h8, NL);
    rdc("rst_ctrl", 32'h0, 0);
    rdc("rst_led3", 32'h10C, 0);

    // register access vectors
    for (int v = 0; v < 18; v++) begin
      logic [31:0] x;
      wb(tv[v].w, tv[v].a, tv[v].d, tv[v].s, x);
      if (!tv[v].w) chk($sformatf("vec%0d", v), x, tv[v].exp);
    end

    // full-throughput frame
    for (int i = 0; i < NL; i++) led_wr(i, 32'(32'h11 * i + 1), 4'hF);
    wbw(32'h8, 0, 4'hF);
    rmode = 0; beats.delete();
    wbw(32'h0, 32'h1, 4'h1);
    wait_beats(NL, 100);
    check_frame("f1", 0, 0);
    for (int k = 1; k < beats.size(); k++) chk("f1_consec", beats[k].stamp - beats[0].stamp, k);
    repeat (30) @(negedge clk);
    chk("f1_no_extra", beats.size(), NL);
    wb(1'b0, 32'h4, 0, 0, st);
    chk("f1_idle", st & 32'h3, 0);

    // toggling ready
    led_wr(2, 32'h00ABCDEF, 4'hF);
    rmode = 1; beats.delete();
    wbw(32'h0, 32'h1, 4'h1);
    wait_beats(NL, 200);
    check_frame("tog", 0, 0);
    repeat (20) @(negedge clk);

    // held stall, LED writes during stall, single-cycle ready
    rmode = 3; beats.delete();
    wbw(32'h0, 32'h1, 4'h1);
    repeat (5) @(negedge clk);
    chk("stall_valid", 32'(ax_valid), 1);
    chk("stall_data", ax_data, mbuf[0]);
    old0 = mbuf[0];
    led_wr(0, 32'hCAFE0000, 4'hF);
    led_wr(5, 32'h55555555, 4'hF);
    @(negedge clk);
    chk("stall_latched", ax_data, old0);
    rmode = 4;
    repeat (4) @(negedge clk);
    chk("oneshot_beats", beats.size(), 1);
    chk("oneshot_next", ax_data, mbuf[1]);
    chk("oneshot_valid", 32'(ax_valid), 1);
    rmode = 0;
    wait_beats(NL, 100);
    tmp = mbuf[0]; mbuf[0] = old0;
    check_frame("upd", 0, 0);
    mbuf[0] = tmp;
    repeat (20) @(negedge clk);

    // frame length
    wbw(32'h8, 32'h3, 4'h1);
    beats.delete();
    wbw(32'h0, 32'h1, 4'h1);
    wait_beats(3, 100);
    check_frame("len3", 0, 3);
    repeat (30) @(negedge clk);
    chk("len3_no_extra", beats.size(), 3);
    wbw(32'h8, 32'h7F, 4'h1);
    beats.delete();
    wbw(32'h0, 32'h1, 4'h1);
    wait_beats(NL, 100);
    check_frame("len7f", 0, 32'h7F);
    repeat (30) @(negedge clk);
    chk("len7f_no_extra", beats.size(), NL);
    wbw(32'h8, 32'h0, 4'h1);

    // auto-repeat
    beats.delete();
    wbw(32'h0, 32'h3, 4'h1);
    wait_beats(3 * NL, 400);
    for (int f = 0; f < 3; f++) check_frame("auto", f * NL, 0);
    chk("auto_gap1", beats[NL].stamp - beats[NL-1].stamp, GAP + 1);
    chk("auto_gap2", beats[2*NL].stamp - beats[2*NL-1].stamp, GAP + 1);
    wbw(32'h0, 32'h0, 4'h1);
    wait_idle();
    n = beats.size();
    chk("auto_whole_frames", n % NL, 0);
    chk("auto_final_last", 32'(beats[n-1].last), 1);
    repeat (40) @(negedge clk);
    chk("auto_stopped", beats.size(), n);

    // START while busy -> exactly one more frame
    rmode = 3; beats.delete();
    wbw(32'h0, 32'h1, 4'h1);
    wbw(32'h0, 32'h1, 4'h1);
    wb(1'b0, 32'h4, 0, 0, st);
    chk("pend_status", st & 32'h3, 32'h3);
    rmode = 0;
    wait_beats(2 * NL, 300);
    check_frame("pend_f1", 0, 0);
    check_frame("pend_f2", NL, 0);
    chk("pend_gap", beats[NL].stamp - beats[NL-1].stamp, GAP + 1);
    repeat (50) @(negedge clk);
    chk("pend_no_extra", beats.size(), 2 * NL);
    wb(1'b0, 32'h4, 0, 0, st);
    chk("pend_idle", st & 32'h3, 0);

    // reset mid-frame
    rmode = 3; beats.delete();
    wbw(32'h8, 32'h5, 4'h1);
    wbw(32'h0, 32'h1, 4'h1);
    repeat (3) @(negedge clk);
    chk("mid_valid", 32'(ax_valid), 1);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(ax_valid), 0);
    chk("mid_rst_last", 32'(ax_last), 0);
    chk("mid_rst_data", ax_data, 0);
    rst_n = 1; rmode = 0;
    for (int i = 0; i < NL; i++) mbuf[i] = 0;
    rdc("mid_len", 32'h8, NL);
    rdc("mid_led0", 32'h100, 0);
    rdc("mid_status", 32'h4, 0);
    repeat (20) @(negedge clk);
    chk("mid_no_resume", beats.size(), 0);

    // random frames against the model
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NL; i++)
        led_wr(i, $urandom, (it % 2 == 1) ? 4'($urandom_range(1, 15)) : 4'hF);
      raw = $urandom_range(0, 15);
      wbw(32'h8, 32'(raw), 4'h1);
      rmode = 2; beats.delete();
      wbw(32'h0, 32'h1, 4'h1);
      wait_beats(eff_len(raw), 400);
      check_frame($sformatf("rnd%0d", it), 0, raw);
      repeat (25) @(negedge clk);
      chk("rnd_no_extra", beats.size(), eff_len(raw));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
